// File: rtl/frame_loader.sv
// Raster pixel stream to frame-buffer writes with framing checks and frame hand-off; one register stage stream->write.
// Backpressure: s_ready is held low from the last accepted pixel until the downstream stage acks the resident frame.
module frame_loader #(
    parameter int IMG_WD     = 16,
    parameter int IMG_HT     = 16,
    parameter int COORD_BITS = 5,
    parameter int IN_BITS    = 8,
    parameter int PXL_BITS   = 11,
    parameter int CNT_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_BITS-1:0]         s_data,
    input  logic                       s_sof,
    input  logic                       s_eol,
    output logic                       wr_en,
    output logic [COORD_BITS-1:0]      wr_x,
    output logic [COORD_BITS-1:0]      wr_y,
    output logic signed [PXL_BITS-1:0] wr_data_pxl,
    output logic                       frame_rdy,
    input  logic                       frame_ack,
    output logic                       err_sof,
    output logic                       err_eol,
    output logic [CNT_BITS-1:0]        frame_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_WD - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_HT - 1);
    localparam logic [COORD_BITS-1:0] C_ONE  = COORD_BITS'(1);

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
        logic [PXL_BITS-1:0]   pxl;
    } wr_beat_t;

    logic [1:0]            state_q, state_d;
    logic [COORD_BITS-1:0] x_q, x_d;
    logic [COORD_BITS-1:0] y_q, y_d;
    logic                  wr_en_q, wr_en_d;
    wr_beat_t              wr_q, wr_d;
    logic                  frame_rdy_q, frame_rdy_d;
    logic                  err_sof_q, err_sof_d;
    logic                  err_eol_q, err_eol_d;
    logic [CNT_BITS-1:0]   frame_cnt_q, frame_cnt_d;

    logic                  accept;
    logic                  last_col;
    logic [PXL_BITS-1:0]   pxl_ext;

    assign s_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept   = s_valid && s_ready;
    assign last_col = (x_q == X_LAST);
    assign pxl_ext  = {{(PXL_BITS - IN_BITS){1'b0}}, s_data};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        wr_en_d     = 1'b0;
        wr_d        = wr_q;
        frame_rdy_d = frame_rdy_q;
        err_sof_d   = 1'b0;
        err_eol_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && s_sof) begin
                    wr_en_d  = 1'b1;
                    wr_d.x   = '0;
                    wr_d.y   = '0;
                    wr_d.pxl = pxl_ext;
                    x_d      = C_ONE;
                    y_d      = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en_d  = 1'b1;
                    wr_d.pxl = pxl_ext;
                    // A restart wins over the row-length check on the same beat.
                    if (s_sof) begin
                        err_sof_d = 1'b1;
                        wr_d.x    = '0;
                        wr_d.y    = '0;
                        x_d       = C_ONE;
                        y_d       = '0;
                    end else begin
                        wr_d.x = x_q;
                        wr_d.y = y_q;
                        if (s_eol != last_col) begin
                            err_eol_d = 1'b1;
                            x_d       = '0;
                            y_d       = '0;
                            state_d   = ST_IDLE;
                        end else if (last_col) begin
                            x_d = '0;
                            if (y_q == Y_LAST) begin
                                y_d     = '0;
                                state_d = ST_DONE;
                            end else begin
                                y_d = y_q + C_ONE;
                            end
                        end else begin
                            x_d = x_q + C_ONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                // The final write commits this cycle, so the frame is announced one cycle later.
                frame_rdy_d = 1'b1;
                frame_cnt_d = frame_cnt_q + CNT_BITS'(1);
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    frame_rdy_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            wr_en_q     <= 1'b0;
            wr_q        <= '0;
            frame_rdy_q <= 1'b0;
            err_sof_q   <= 1'b0;
            err_eol_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wr_en_q     <= wr_en_d;
            wr_q        <= wr_d;
            frame_rdy_q <= frame_rdy_d;
            err_sof_q   <= err_sof_d;
            err_eol_q   <= err_eol_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_x        = wr_q.x;
    assign wr_y        = wr_q.y;
    assign wr_data_pxl = wr_q.pxl;
    assign frame_rdy   = frame_rdy_q;
    assign err_sof     = err_sof_q;
    assign err_eol     = err_eol_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Randomized stream stimulus against a frame-level reference model; writes are scoreboarded and checked by a monitor.
module tb_frame_loader;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CB = 3;
    localparam int IB = 8;
    localparam int PB = 11;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          s_eol = 1'b0;
    logic          frame_ack = 1'b0;
    logic [IB-1:0] s_data = '0;
    logic          s_ready, wr_en, frame_rdy, err_sof, err_eol;
    logic [CB-1:0] wr_x, wr_y;
    logic [PB-1:0] wr_data_pxl;
    logic [NB-1:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_loader #(
        .IMG_WD(W), .IMG_HT(H), .COORD_BITS(CB), .IN_BITS(IB), .PXL_BITS(PB), .CNT_BITS(NB)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data_pxl(wr_data_pxl),
        .frame_rdy(frame_rdy), .frame_ack(frame_ack),
        .err_sof(err_sof), .err_eol(err_eol), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame-level view of the stream ----------------
    typedef struct { int x; int y; int d; } wr_exp_t;
    typedef enum int { M_IDLE, M_LOAD, M_FULL } mode_t;

    wr_exp_t wq[$];
    mode_t   mode   = M_IDLE;
    int      pos    = 0;
    int      age    = 0;
    int      m_cnt  = 0;
    bit      m_esof = 1'b0;
    bit      m_eeol = 1'b0;

    function automatic void push_wr(input int x, input int y, input int d);
        wr_exp_t e;
        e.x = x; e.y = y; e.d = d;
        wq.push_back(e);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mode = M_IDLE; pos = 0; age = 0; m_cnt = 0;
            m_esof = 1'b0; m_eeol = 1'b0;
            wq.delete();
        end else begin
            m_esof = 1'b0;
            m_eeol = 1'b0;
            if (mode == M_FULL) begin
                if (age == 0) begin
                    age   = 1;
                    m_cnt = (m_cnt + 1) % (1 << NB);
                end else if (frame_ack) begin
                    mode = M_IDLE;
                end
            end else if (s_valid) begin
                if (s_sof) begin
                    if (mode == M_LOAD) m_esof = 1'b1;
                    push_wr(0, 0, int'(s_data));
                    pos  = 1;
                    mode = M_LOAD;
                end else if (mode == M_LOAD) begin
                    push_wr(pos % W, pos / W, int'(s_data));
                    if (s_eol != ((pos % W) == W - 1)) begin
                        m_eeol = 1'b1;
                        mode   = M_IDLE;
                        pos    = 0;
                    end else if (pos == W * H - 1) begin
                        mode = M_FULL;
                        age  = 0;
                    end else begin
                        pos++;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    wr_exp_t mon_e;
    int      last_x = 0;
    int      last_y = 0;

    always @(negedge clk) begin
        if (rst) begin
            last_x = 0;
            last_y = 0;
        end else begin
            if (wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", wr_en, 0);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wr_x", wr_x, mon_e.x);
                    chk("wr_y", wr_y, mon_e.y);
                    chk("wr_data", wr_data_pxl, mon_e.d);
                    last_x = mon_e.x;
                    last_y = mon_e.y;
                end
            end else begin
                chk("wr_x_hold", wr_x, last_x);
                chk("wr_y_hold", wr_y, last_y);
            end
            chk("s_ready", s_ready, mode != M_FULL);
            chk("frame_rdy", frame_rdy, (mode == M_FULL) && (age >= 1));
            chk("frame_cnt", frame_cnt, m_cnt);
            chk("err_sof", err_sof, m_esof);
            chk("err_eol", err_eol, m_eeol);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] d, input bit sof, input bit eol, input int gap);
        int g;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
        for (int i = 0; i < 40 && s_ready !== 1'b1; i++) @(negedge clk);
        if (s_ready !== 1'b1) chk("send_ready_timeout", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    function automatic logic [7:0] pix(input bit rnd, input int p);
        return rnd ? 8'($urandom_range(255)) : 8'(p);
    endfunction

    task automatic send_frame(input bit rnd, input int gap);
        for (int p = 0; p < W * H; p++) send(pix(rnd, p), p == 0, (p % W) == W - 1, gap);
    endtask

    task automatic release_frame();
        int i;
        i = 0;
        @(negedge clk);
        while (frame_rdy !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("frame_rdy_wait", frame_rdy, 1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_x"}, wr_x, 0);
        chk({tag, "_wr_y"}, wr_y, 0);
        chk({tag, "_wr_data"}, wr_data_pxl, 0);
        chk({tag, "_frame_rdy"}, frame_rdy, 0);
        chk({tag, "_err_sof"}, err_sof, 0);
        chk({tag, "_err_eol"}, err_eol, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1);

        // clean frame, data 0..15, then frame_rdy two cycles after the last accept
        send_frame(1'b0, 0);
        @(negedge clk);
        chk("rdy_n_plus_1", frame_rdy, 0);
        @(negedge clk);
        chk("rdy_n_plus_2", frame_rdy, 1);
        chk("cnt_first_frame", frame_cnt, 1);
        chk("ready_in_hold", s_ready, 0);

        // beats offered during HOLD must be ignored
        s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h55;
        repeat (4) @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0;
        release_frame();

        // non-sof beats in IDLE are dropped; frame_ack during LOAD has no effect
        repeat (3) send(8'hAA, 1'b0, 1'b0, 0);
        for (int p = 0; p < W * H; p++) begin
            frame_ack = (p < 8);
            send(pix(1'b1, p), p == 0, (p % W) == W - 1, 1);
        end
        frame_ack = 1'b0;
        release_frame();

        // early eol at x=2, y=1
        for (int p = 0; p < 6; p++) send(pix(1'b1, p), p == 0, (p % W) == W - 1, 0);
        send(8'h66, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clk);

        // sof at x=3, y=2 restarts the frame
        for (int p = 0; p < 11; p++) send(pix(1'b1, p), p == 0, (p % W) == W - 1, 0);
        send(8'h77, 1'b1, 1'b0, 0);
        for (int p = 1; p < W * H; p++) send(pix(1'b1, p), 1'b0, (p % W) == W - 1, 0);
        release_frame();

        // reset after pixel 7 with random gaps
        for (int p = 0; p < 8; p++) send(pix(1'b1, p), p == 0, (p % W) == W - 1, 3);
        rst = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("no_wr_after_reset", wr_en, 0);
        send_frame(1'b1, 2);
        repeat (2) @(negedge clk);
        chk("cnt_after_reset", frame_cnt, 1);
        release_frame();

        // eight more frames wrap the counter back to 1
        repeat (8) begin
            send_frame(1'b1, 1);
            release_frame();
        end
        chk("cnt_wrapped", frame_cnt, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
